// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory arbiter.
// Holds the FSM states, the request owners, the access-size encodings and the latched request payload.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd3;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_latch.sv
// mem_req_latch: holds one requester's pending bit and request payload.
// A request pulse is taken only while nothing is pending. While clear is high, no new request is taken.
module mem_req_latch
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     req,
    input  mem_req_t req_data,
    input  logic     clear,
    output logic     pending,
    output mem_req_t data
);

    // NOTE: every flop uses non-blocking (<=) so all registers update from their pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            // NOTE: the payload is reset as well; it is a handful of flops and keeps mc_* deterministic.
            data    <= '0;
        end else if (rdy) begin
            if (clear) begin
                pending <= 1'b0;
            end else if (req && !pending) begin
                pending <= 1'b1;
                data    <= req_data;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory controller between the instruction cache (IC) and the load/store buffer (LSB).
// Defining MEM_ARB_STARVE_GUARD_EN enables the starvation guard, which forces an IC grant after STARVE_LIMIT consecutive LSB grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [1:0]  IO_BASE_HI   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_size,
    input  logic        lsb_signed,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        flush,
    input  logic        io_buffer_full,
    output logic        mc_valid,
    output logic        mc_we,
    output logic [1:0]  mc_size,
    output logic        mc_signed,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_ready,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    state_t   state;
    owner_t   owner;
    mem_req_t ic_in, lsb_in, ic_q, lsb_q, sel;
    logic     ic_pend, lsb_pend, ic_clear, lsb_clear;
    logic     ic_kill, finish, ic_elig, lsb_elig, pick_ic, grant;
    logic     mc_valid_q, ic_done_q, lsb_done_q;

    assign ic_in  = '{we: 1'b0, size: SIZE_W, sgn: 1'b0, addr: ic_addr, wdata: 32'd0};
    assign lsb_in = '{we: lsb_we, size: lsb_size, sgn: lsb_signed, addr: lsb_addr, wdata: lsb_wdata};

    // A flushed in-flight fetch keeps its slot until mc_done, but it must not clear a fetch latched after the flush.
    assign finish    = (state == ST_WAIT) && mc_done;
    assign ic_clear  = flush || (finish && owner == OWN_IC && !ic_kill);
    assign lsb_clear = finish && owner == OWN_LSB;

    mem_req_latch u_ic_latch (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .req      (ic_req),
        .req_data (ic_in),
        .clear    (ic_clear),
        .pending  (ic_pend),
        .data     (ic_q)
    );

    mem_req_latch u_lsb_latch (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .req      (lsb_req),
        .req_data (lsb_in),
        .clear    (lsb_clear),
        .pending  (lsb_pend),
        .data     (lsb_q)
    );

    // An IO-space store waits while the IO buffer is full.
    assign lsb_elig = lsb_pend && !(lsb_q.we && lsb_q.addr[17:16] == IO_BASE_HI && io_buffer_full);
    assign ic_elig  = ic_pend && !flush;
    assign grant    = (state == ST_IDLE) && mc_ready && (ic_elig || lsb_elig);
    assign sel      = pick_ic ? ic_q : lsb_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned         CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    STARVE_MAX = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt;

    assign pick_ic = ic_elig && (!lsb_elig || starve_cnt >= STARVE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rdy && grant) begin
            if (!pick_ic && ic_elig) starve_cnt <= starve_cnt + 1'b1;
            else                     starve_cnt <= '0;
        end
    end
`else
    assign pick_ic = ic_elig && !lsb_elig;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IC;
            ic_kill    <= 1'b0;
            mc_valid_q <= 1'b0;
            mc_we      <= 1'b0;
            mc_size    <= 2'd0;
            mc_signed  <= 1'b0;
            mc_addr    <= 32'd0;
            mc_wdata   <= 32'd0;
            ic_done_q  <= 1'b0;
            ic_data    <= 32'd0;
            lsb_done_q <= 1'b0;
            lsb_rdata  <= 32'd0;
        end else if (rdy) begin
            ic_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            if (flush && owner == OWN_IC && state != ST_IDLE) ic_kill <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner      <= pick_ic ? OWN_IC : OWN_LSB;
                        mc_we      <= sel.we;
                        mc_size    <= sel.size;
                        mc_signed  <= sel.sgn;
                        mc_addr    <= sel.addr;
                        mc_wdata   <= sel.wdata;
                        mc_valid_q <= 1'b1;
                        ic_kill    <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mc_valid_q <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mc_done) begin
                        state   <= ST_IDLE;
                        ic_kill <= 1'b0;
                        if (owner == OWN_LSB) begin
                            lsb_done_q <= 1'b1;
                            lsb_rdata  <= mc_rdata;
                        end else if (!ic_kill && !flush) begin
                            ic_done_q <= 1'b1;
                            ic_data   <= mc_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked while stalled; the frozen state re-presents them once rdy returns.
    assign mc_valid = mc_valid_q && rdy;
    assign ic_done  = ic_done_q && rdy;
    assign lsb_done = lsb_done_q && rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned STARVE = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic        ic_req = 1'b0, lsb_req = 1'b0, lsb_we = 1'b0, lsb_signed = 1'b0;
    logic [31:0] ic_addr = '0, lsb_addr = '0, lsb_wdata = '0, mc_rdata = '0;
    logic [1:0]  lsb_size = '0;
    logic        flush = 1'b0, io_buffer_full = 1'b0, mc_ready = 1'b0, mc_done = 1'b0;
    logic        ic_done, lsb_done, mc_valid, mc_we, mc_signed;
    logic [31:0] ic_data, lsb_rdata, mc_addr, mc_wdata;
    logic [1:0]  mc_size;

    int n_cmp = 0;
    int n_mis = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE), .IO_BASE_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mc_valid(mc_valid), .mc_we(mc_we), .mc_size(mc_size), .mc_signed(mc_signed),
        .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: requester slots 0 = IC, 1 = LSB; one transaction in flight at a time.
    bit          m_pend [2];
    mem_req_t    m_pay  [2];
    int          m_step;          // 0 = free, 1 = just issued, 2 = awaiting mc_done
    int          m_own;
    bit          m_drop;          // in-flight fetch was flushed
    int          m_streak;
    bit          x_valid, x_icd, x_lsbd;
    logic [31:0] x_icdata, x_lsbdata;
    mem_req_t    x_mc;

    task automatic model_edge();
        bit ic_ok, lsb_ok, ic_wins, grant, fin;
        bit np0, np1;
        mem_req_t npay0, npay1;
        if (rst) begin
            m_pend = '{0, 0}; m_pay[0] = '0; m_pay[1] = '0;
            m_step = 0; m_own = 0; m_drop = 0; m_streak = 0;
            x_valid = 0; x_icd = 0; x_lsbd = 0; x_icdata = '0; x_lsbdata = '0; x_mc = '0;
            return;
        end
        if (!rdy) return;
        ic_ok   = m_pend[0] && !flush;
        lsb_ok  = m_pend[1] && !(m_pay[1].we && m_pay[1].addr[17:16] == 2'b11 && io_buffer_full);
        ic_wins = ic_ok && (!lsb_ok || (GUARD && m_streak >= int'(STARVE)));
        grant   = (m_step == 0) && mc_ready && (ic_ok || lsb_ok);
        fin     = (m_step == 2) && mc_done;
        np0 = m_pend[0]; npay0 = m_pay[0];
        np1 = m_pend[1]; npay1 = m_pay[1];
        if (flush || (fin && m_own == 0 && !m_drop)) np0 = 0;
        else if (ic_req && !m_pend[0]) begin
            np0 = 1;
            npay0 = '{we: 1'b0, size: SIZE_W, sgn: 1'b0, addr: ic_addr, wdata: 32'd0};
        end
        if (fin && m_own == 1) np1 = 0;
        else if (lsb_req && !m_pend[1]) begin
            np1 = 1;
            npay1 = '{we: lsb_we, size: lsb_size, sgn: lsb_signed, addr: lsb_addr, wdata: lsb_wdata};
        end
        x_icd = 0; x_lsbd = 0;
        if (grant) begin
            m_own = ic_wins ? 0 : 1;
            x_mc = m_pay[m_own]; x_valid = 1; m_step = 1; m_drop = 0;
            if (GUARD) m_streak = (!ic_wins && ic_ok) ? m_streak + 1 : 0;
        end else if (m_step == 1) begin
            x_valid = 0; m_step = 2;
            if (flush && m_own == 0) m_drop = 1;
        end else if (fin) begin
            m_step = 0;
            if (m_own == 1) begin x_lsbd = 1; x_lsbdata = mc_rdata; end
            else if (!m_drop && !flush) begin x_icd = 1; x_icdata = mc_rdata; end
            m_drop = 0;
        end else if (m_step == 2 && flush && m_own == 0) begin
            m_drop = 1;
        end
        m_pend[0] = np0; m_pay[0] = npay0;
        m_pend[1] = np1; m_pay[1] = npay1;
    endtask

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        cmp("mc_valid",   mc_valid, x_valid & rdy);
        cmp("mc_payload", {mc_we, mc_size, mc_signed, mc_addr, mc_wdata}, x_mc);
        cmp("ic_done",    ic_done, x_icd & rdy);
        cmp("ic_data",    ic_data, x_icdata);
        cmp("lsb_done",   lsb_done, x_lsbd & rdy);
        cmp("lsb_rdata",  lsb_rdata, x_lsbdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rdy = 1; ic_req = 0; lsb_req = 0; flush = 0; io_buffer_full = 0;
        mc_ready = 1; mc_done = 0; mc_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    task automatic set_lsb(input bit we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        lsb_req = 1; lsb_we = we; lsb_size = size; lsb_signed = 0; lsb_addr = addr; lsb_wdata = wdata;
    endtask

    task automatic all_outputs_zero(input string tag);
        cmp(tag, {mc_valid, mc_we, mc_size, mc_signed, mc_addr, mc_wdata,
                  ic_done, ic_data, lsb_done, lsb_rdata}, '0);
    endtask

    initial begin
        // Reset state
        do_reset();
        all_outputs_zero("reset_outputs");

        // Single fetch: mc_valid two edges after the request, then ic_done with the fetched word
        ic_req = 1; ic_addr = 32'h100; tick();
        ic_req = 0; cmp("fetch_not_yet_valid", mc_valid, 1'b0);
        tick(); cmp("fetch_valid_t2", mc_valid, 1'b1); cmp("fetch_addr", mc_addr, 32'h100);
        tick(); cmp("fetch_valid_one_cycle", mc_valid, 1'b0);
        mc_done = 1; mc_rdata = 32'h00A00093; tick();
        mc_done = 0; cmp("fetch_done", ic_done, 1'b1); cmp("fetch_data", ic_data, 32'h00A00093);
        tick(); cmp("fetch_done_pulse", ic_done, 1'b0);

        // Simultaneous requests: load first, fetch right after
        do_reset();
        ic_req = 1; ic_addr = 32'h400; set_lsb(0, SIZE_W, 32'h2000, 0); tick();
        ic_req = 0; lsb_req = 0; tick();
        cmp("both_lsb_first", mc_addr, 32'h2000); cmp("both_lsb_read", mc_we, 1'b0);
        tick(); mc_done = 1; mc_rdata = 32'h12345678; tick();
        mc_done = 0; cmp("both_lsb_done", lsb_done, 1'b1); cmp("both_lsb_rdata", lsb_rdata, 32'h12345678);
        tick(); cmp("both_ic_next", mc_valid, 1'b1); cmp("both_ic_addr", mc_addr, 32'h400);

        // IO store blocked by full buffer: fetch overtakes, store issues one edge after full drops
        do_reset();
        io_buffer_full = 1;
        ic_req = 1; ic_addr = 32'h500; set_lsb(1, SIZE_B, 32'h30000, 32'hAB); tick();
        ic_req = 0; lsb_req = 0; tick();
        cmp("io_ic_granted", mc_addr, 32'h500);
        tick(); mc_done = 1; mc_rdata = 32'h1; tick();
        mc_done = 0; cmp("io_ic_done", ic_done, 1'b1);
        tick(); tick(); cmp("io_store_held", mc_valid, 1'b0);
        io_buffer_full = 0; tick();
        cmp("io_store_issued", mc_valid, 1'b1);
        cmp("io_store_payload", {mc_we, mc_size, mc_addr}, {1'b1, SIZE_B, 32'h30000});

        // Continuous loads with a fetch pending: the fifth grant goes to the fetch only with the guard
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            mc_ready = 0;
            if (k == 1) begin ic_req = 1; ic_addr = 32'h600; end
            set_lsb(0, SIZE_W, 32'h7000 + k, 0); tick();
            ic_req = 0; lsb_req = 0; mc_ready = 1; tick();
            cmp("starve_grant_valid", mc_valid, 1'b1);
            cmp("starve_grant_addr", mc_addr, (k == 5 && GUARD) ? 32'h600 : 32'h7000 + k);
            tick(); mc_done = 1; mc_rdata = k; tick();
            mc_done = 0;
        end

        // Flush during fetch WAIT: completion consumed silently, arbiter free next cycle
        do_reset();
        ic_req = 1; ic_addr = 32'h800; tick();
        ic_req = 0; tick(); tick();
        flush = 1; tick();
        flush = 0; mc_done = 1; mc_rdata = 32'hDEAD; tick();
        mc_done = 0; cmp("flush_no_done", ic_done, 1'b0);
        set_lsb(0, SIZE_H, 32'h44, 0); tick();
        lsb_req = 0; tick();
        cmp("flush_idle_next", mc_valid, 1'b1); cmp("flush_next_addr", mc_addr, 32'h44);

        // Stall: mc_valid drops while rdy is low and returns with it
        do_reset();
        set_lsb(0, SIZE_W, 32'h88, 0); tick();
        lsb_req = 0; tick();
        rdy = 0; #1 cmp("stall_valid_drop", mc_valid, 1'b0);
        tick(); tick();
        rdy = 1; #1 cmp("stall_valid_back", mc_valid, 1'b1);
        tick(); rdy = 0; mc_done = 1; mc_rdata = 32'h55; tick();
        cmp("stall_done_held", lsb_done, 1'b0);
        rdy = 1; tick(); mc_done = 0;
        cmp("stall_done_after", lsb_done, 1'b1);

        // Reset in WAIT abandons the access; stray mc_done ignored; next request served normally
        do_reset();
        set_lsb(0, SIZE_W, 32'h99, 0); tick();
        lsb_req = 0; tick(); tick();
        rst = 1; tick();
        rst = 0; all_outputs_zero("rst_wait_outputs");
        mc_done = 1; tick();
        mc_done = 0; cmp("rst_no_done", lsb_done, 1'b0);
        ic_req = 1; ic_addr = 32'h900; tick();
        ic_req = 0; tick(); cmp("rst_next_addr", mc_addr, 32'h900);
        tick(); mc_done = 1; mc_rdata = 32'hCAFE; tick();
        mc_done = 0; cmp("rst_next_data", ic_data, 32'hCAFE);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            rdy            = ($urandom_range(0, 7) != 0);
            ic_req         = ($urandom_range(0, 3) == 0);
            ic_addr        = $urandom;
            lsb_req        = ($urandom_range(0, 3) == 0);
            lsb_we         = 1'($urandom_range(0, 1));
            lsb_size       = ($urandom_range(0, 2) == 2) ? SIZE_W : 2'($urandom_range(0, 1));
            lsb_signed     = 1'($urandom_range(0, 1));
            lsb_addr       = $urandom;
            lsb_wdata      = $urandom;
            flush          = ($urandom_range(0, 15) == 0);
            io_buffer_full = 1'($urandom_range(0, 1));
            mc_ready       = ($urandom_range(0, 3) != 0);
            mc_done        = ($urandom_range(0, 2) == 0);
            mc_rdata       = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
